// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Bundles the ROM port, the redirect request and the decode-side handshake of
// the instruction fetch sequencer.
//   ADDR/INST            : byte address to the combinational ROM and its word
//   redirect/redirect_pc : one-cycle flush request and its target
//   out_valid/out_ready  : decode handshake; out_inst/out_pc carry the head entry
//   halted               : end-of-program word fetched, fetching stopped
//   retired_count        : number of accepted handshakes
//   dbg_state            : FSM state (0 = RUN, 1 = HALT)
//
// Handshake: an entry transfers on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the sequencer holds
// out_inst/out_pc stable. out_valid never depends on out_ready, and out_ready
// may be asserted at any time, including while out_valid=0.
interface fetch_sequencer_if;
  logic [31:0] ADDR;
  logic [31:0] INST;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] retired_count;
  logic        dbg_state;

  modport master (
    output ADDR, out_valid, out_inst, out_pc, halted, retired_count, dbg_state,
    input  INST, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  ADDR, out_valid, out_inst, out_pc, halted, retired_count, dbg_state,
    output INST, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction fetch controller. Owns the PC, drives the ROM address, captures
// each returned word with its PC into a circular fetch buffer and hands
// entries to decode over a valid/ready handshake. A redirect flushes the
// buffer and refetches from the target; an all-zero word marks end of program
// and stops fetching until the next redirect or reset.
// Ports:
//   CLK  : single clock, rising edge
//   RST  : synchronous, active-high reset
//   bus  : fetch_sequencer_if.master (ROM port, redirect, decode handshake,
//          halted, retired_count, dbg_state)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic                CLK,
  input logic                RST,
  fetch_sequencer_if.master  bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t             state;
  logic [31:0]        pc;
  logic [31:0]        inst_mem [BUF_DEPTH];
  logic [31:0]        pc_mem   [BUF_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               halted_q;
  logic [31:0]        retired_q;

  logic pop;
  logic push_ok;
  logic is_end;
  logic push;

  // A full buffer still accepts a push when the head leaves in the same
  // cycle, which keeps throughput at one per cycle with no bubble.
  assign pop     = (count != '0) && bus.out_ready;
  assign push_ok = (state == RUN) && !bus.redirect &&
                   ((count < CNT_W'(BUF_DEPTH)) || pop);
  assign is_end  = (bus.INST == 32'h0);
  assign push    = push_ok && !is_end;

  assign bus.ADDR          = pc;
  assign bus.out_valid     = (count != '0);
  assign bus.out_inst      = inst_mem[head];
  assign bus.out_pc        = pc_mem[head];
  assign bus.halted        = halted_q;
  assign bus.retired_count = retired_q;
  assign bus.dbg_state     = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      pc        <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      halted_q  <= 1'b0;
      retired_q <= 32'h0;
      // Storage is cleared so the head reads 0 out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        inst_mem[i] <= 32'h0;
        pc_mem[i]   <= 32'h0;
      end
    end else begin
      // A pop retires even when a redirect discards its entry.
      if (pop) begin
        retired_q <= retired_q + 32'd1;
      end

      if (bus.redirect) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        pc       <= {bus.redirect_pc[31:2], 2'b00};
        state    <= RUN;
        halted_q <= 1'b0;
      end else begin
        if (push) begin
          inst_mem[tail] <= bus.INST;
          pc_mem[tail]   <= pc;
          tail           <= tail + PTR_W'(1);
          pc             <= pc + 32'd4;
        end

        // The end word is not buffered and the PC stays on it.
        if (push_ok && is_end) begin
          state    <= HALT;
          halted_q <= 1'b1;
        end

        if (pop) begin
          head <= head + PTR_W'(1);
        end

        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer with BUF_DEPTH=2 and RESET_PC=0. A small
// ROM model answers ADDR combinationally. The main sequence pushes expected
// {pc, inst} pairs into exp_q before releasing out_ready; a monitor on the
// falling edge pops and compares every handshake. Point checks on ADDR,
// halted, out_valid and retired_count are made 1 time unit after rising edges.
module tb_fetch_sequencer;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  fetch_sequencer_if bus();

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ROM image: the sort program ends with a zero word at 0x4C. A single
  // extra word at the top of memory lets the PC wrap be observed.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h0;
    if (a < 32'h4C) begin
      case (a[6:2])
        5'd0:    w = 32'h00000533;
        5'd1:    w = 32'h00000333;
        5'd2:    w = 32'h000002b3;
        5'd3:    w = 32'h00000393;
        5'd4:    w = 32'h00b50e33;
        5'd5:    w = 32'h000e2e83;
        5'd6:    w = 32'h004e2f03;
        5'd7:    w = 32'h01df5863;
        5'd8:    w = 32'h01ee2023;
        5'd9:    w = 32'h01de2223;
        5'd10:   w = 32'h00138393;
        5'd11:   w = 32'h00430313;
        5'd12:   w = 32'hfe6ec4e3;
        5'd13:   w = 32'h00150513;
        5'd14:   w = 32'h00050293;
        5'd15:   w = 32'h00428293;
        5'd16:   w = 32'hf8559ce3;
        5'd17:   w = 32'h00000013;
        5'd18:   w = 32'h00008067;
        default: w = 32'h0;
      endcase
    end else if (a == 32'hFFFF_FFFC) begin
      w = 32'h00000093;
    end
    return w;
  endfunction

  assign bus.INST = rom_word(bus.ADDR);

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({pc, inst});
  endtask

  // Monitor: the handshake completes on the next rising edge.
  always @(negedge CLK) begin
    if (!RST && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL handshake: got pc %0h inst %0h expected no entry",
                 bus.out_pc, bus.out_inst);
      end else begin
        mon_exp = exp_q.pop_front();
        check("handshake", {bus.out_pc, bus.out_inst}, mon_exp);
      end
    end
  end

  initial begin
    RST             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_addr",    bus.ADDR,          32'h0);
    check("rst_valid",   bus.out_valid,     1'b0);
    check("rst_halted",  bus.halted,        1'b0);
    check("rst_retired", bus.retired_count, 32'h0);
    check("rst_inst",    bus.out_inst,      32'h0);
    check("rst_pc",      bus.out_pc,        32'h0);

    // Sort program head with out_ready=1: one per cycle
    expect_entry(32'h00, 32'h00000533);
    expect_entry(32'h04, 32'h00000333);
    expect_entry(32'h08, 32'h000002b3);
    RST           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    check("a_retired", bus.retired_count, 32'd3);
    check("a_addr",    bus.ADDR,          32'h10);

    RST = 1'b1;
    tick();
    check("rst2_valid", bus.out_valid, 1'b0);
    RST = 1'b0;

    // Backpressure for 6 cycles: buffer fills with 0x00, 0x04
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_inst_stable", bus.out_inst, 32'h00000533);
    end
    check("bp_addr", bus.ADDR,   32'h08);
    check("bp_pc",   bus.out_pc, 32'h00);
    expect_entry(32'h00, 32'h00000533);
    expect_entry(32'h04, 32'h00000333);
    expect_entry(32'h08, 32'h000002b3);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    check("bp_retired", bus.retired_count, 32'd3);
    check("bp_addr2",   bus.ADDR,          32'h14);
    check("bp_head",    bus.out_pc,        32'h0C);

    // Redirect with a full buffer; target low bits ignored
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3E;
    tick();
    bus.redirect = 1'b0;
    check("rd_valid", bus.out_valid, 1'b0);
    check("rd_addr",  bus.ADDR,      32'h3C);

    // Run to the end of the program
    expect_entry(32'h3C, 32'h00428293);
    expect_entry(32'h40, 32'hf8559ce3);
    expect_entry(32'h44, 32'h00000013);
    expect_entry(32'h48, 32'h00008067);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("end_not_halted", bus.halted, 1'b0);
    check("end_addr_pre",   bus.ADDR,   32'h4C);
    tick();
    check("end_halted",  bus.halted,        1'b1);
    check("end_state",   bus.dbg_state,     1'b1);
    check("end_addr",    bus.ADDR,          32'h4C);
    check("end_valid",   bus.out_valid,     1'b0);
    check("end_retired", bus.retired_count, 32'd7);
    repeat (2) tick();
    check("halt_addr_frozen", bus.ADDR,   32'h4C);
    check("halt_stays",       bus.halted, 1'b1);

    // Halt with one entry still buffered
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h44;
    tick();
    bus.redirect = 1'b0;
    check("rh_halted_drop", bus.halted,    1'b0);
    check("rh_state",       bus.dbg_state, 1'b0);
    repeat (3) tick();
    check("rh_addr", bus.ADDR,   32'h4C);
    check("rh_head", bus.out_pc, 32'h44);
    expect_entry(32'h44, 32'h00000013);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hb_halted",  bus.halted,        1'b1);
    check("hb_valid",   bus.out_valid,     1'b1);
    check("hb_head",    bus.out_pc,        32'h48);
    check("hb_retired", bus.retired_count, 32'd8);

    // From HALT: redirect to 0 with a simultaneous pop
    expect_entry(32'h48, 32'h00008067);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b1;
    tick();
    bus.redirect  = 1'b0;
    bus.out_ready = 1'b0;
    check("hr_retired", bus.retired_count, 32'd9);
    check("hr_halted",  bus.halted,        1'b0);
    check("hr_valid",   bus.out_valid,     1'b0);
    tick();
    check("hr_valid2", bus.out_valid, 1'b1);
    check("hr_inst",   bus.out_inst,  32'h00000533);
    check("hr_pc",     bus.out_pc,    32'h0);
    tick();

    // RST overrides a simultaneous redirect and pop
    RST             = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3C;
    bus.out_ready   = 1'b1;
    tick();
    RST           = 1'b0;
    bus.redirect  = 1'b0;
    bus.out_ready = 1'b0;
    check("mr_valid",   bus.out_valid,     1'b0);
    check("mr_addr",    bus.ADDR,          32'h0);
    check("mr_retired", bus.retired_count, 32'h0);
    check("mr_halted",  bus.halted,        1'b0);
    tick();
    check("mr_first_valid", bus.out_valid, 1'b1);
    check("mr_first_pc",    bus.out_pc,    32'h0);

    // PC wrap from the top of the address space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    check("wr_addr",  bus.ADDR,      32'hFFFF_FFFC);
    check("wr_valid", bus.out_valid, 1'b0);
    expect_entry(32'hFFFF_FFFC, 32'h00000093);
    expect_entry(32'h0000_0000, 32'h00000533);
    bus.out_ready = 1'b1;
    tick();
    check("wr_pc_wrap", bus.ADDR, 32'h0);
    tick();
    tick();
    bus.out_ready = 1'b0;
    check("wr_retired", bus.retired_count, 32'd2);

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller that sequences the combinational instruction ROM. It owns the program counter and drives the ROM address. Each returned word is captured with its PC into a small FIFO fetch buffer, and entries are handed to decode over a valid/ready handshake. It also handles branch/jump redirects and detects end-of-program, which is the all-zero word the ROM returns outside the loaded program.

## Interface
- RESET_PC, 0: PC loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2: fetch buffer entries; power of two, 2..8.
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- ADDR  output  32  byte address to the instruction ROM; equals the PC register.
- INST  input  32  ROM word for ADDR; combinational, valid the same cycle.
- redirect  input  1  one-cycle pulse; flush and refetch from redirect_pc.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
- out_valid  output  1  buffer head holds an instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_inst  output  32  head instruction word.
- out_pc  output  32  head instruction address.
- halted  output  1  end-of-program word fetched; fetching stopped.
- retired_count  output  32  number of accepted handshakes (out_valid & out_ready).

## Operation
- States: RUN, HALT. Reset enters RUN with PC=RESET_PC, buffer empty, retired_count=0.
- pop = out_valid & out_ready. Push is permitted when state=RUN, redirect=0, and either count<BUF_DEPTH or pop=1.
- On a permitted push with INST!=0: write {ADDR, INST} at the tail, then PC <= PC+4. The increment is 32-bit and wraps 0xFFFFFFFC -> 0.
- On a permitted push with INST==0: the word is not written, PC holds, and the state moves to HALT. Entries already buffered still drain normally.
- HALT: no push, ADDR frozen at the halting address, halted=1.
- redirect=1, in any state, has highest priority:
  - Buffer is flushed (count=0).
  - PC <= {redirect_pc[31:2],2'b00}; state <= RUN.
  - No push that cycle.
  - A pop in the same cycle still counts in retired_count, but its entry is discarded by the flush.
- FIFO: circular, head/tail pointers of log2(BUF_DEPTH) bits that wrap, plus a count from 0..BUF_DEPTH. Push and pop in the same cycle leave count unchanged.
- out_inst/out_pc are driven from head storage. They are don't-care while out_valid=0, but must be stable while out_valid=1 and out_ready=0.
- retired_count increments by 1 per pop, wraps at 2^32, is unaffected by redirect, and is cleared only by RST.

## Timing
- Reset values: ADDR=RESET_PC, out_valid=0, halted=0, retired_count=0. out_inst and out_pc are 0.
- Fetch latency is one cycle: a word pushed in cycle n is visible at out_valid/out_inst in cycle n+1.
- First instruction after RST deasserts appears at out_valid one cycle later.
- Throughput: one instruction per cycle sustained with out_ready held at 1.
- Full buffer with a pop in the same cycle: the push proceeds, so there is no bubble.
- Redirect in cycle n: out_valid=0 in n+1. The target instruction is presented in n+2, since the target is fetched in n+1.
- halted rises the cycle after the zero word is sampled. It falls the cycle after a redirect or RST.
- RST mid-operation overrides everything, including a simultaneous redirect or pop. The buffer is discarded.

## Test plan
- Reset then out_ready=1, ROM loaded with the sort program:
  - Head sequence is (pc 0x00, 00000533), (0x04, 00000333), (0x08, 000002b3), one per cycle.
  - retired_count=3 after three handshakes.
- Backpressure, out_ready=0 for 6 cycles after reset:
  - Buffer holds pc 0x00 and 0x04; ADDR stays 0x08; out_inst stable at 00000533.
  - Releasing out_ready yields 0x00, 0x04, 0x08 with no loss or duplication.
- Redirect with a full buffer: assert redirect with redirect_pc=0x3E.
  - out_valid=0 the next cycle.
  - Then (pc 0x3C, 00428293), followed by (0x40, f8559ce3).
- Run to the end of the program with out_ready=1:
  - Last delivered entry is (0x48, 00008067); the zero word at 0x4C is not delivered.
  - halted=1 and ADDR=0x4C; out_valid falls once drained.
- From HALT, redirect to 0x00 with a simultaneous pop:
  - retired_count increments and halted drops.
  - 00000533 is presented two cycles later.
- Assert RST for one cycle mid-stream with a 2-entry buffer and redirect=1:
  - Next cycle out_valid=0, ADDR=RESET_PC, retired_count=0, halted=0.
